imem_loader: RTL

Boot-time instruction-memory loader that sits directly upstream of the single-cycle RV32 core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes them sequentially into the core's word-addressed instruction memory from address 0, holding the core in reset until the programmed word count has been written. It also produces a 32-bit additive checksum of the loaded image for host-side confirmation.

---
 rtl/imem_loader.sv | 110 +++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot-time loader: assembles little-endian words from a byte stream, writes them
// into instruction memory from address 0 and holds the core in reset until done.
module imem_loader #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 9
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   wordCount,
   input  logic [7:0]        inData,
   input  logic              inValid,
   output logic              inReady,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [WIDTH-1:0]  memWdata,
   output logic              cpuReset,
   output logic              busy,
   output logic              done,
   output logic [31:0]       checksum
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_t              state_q, state_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [1:0]          byte_q, byte_d;
   logic [ADDR_W-1:0]   widx_q, widx_d;
   logic [WIDTH-1:0]    word_q, word_d;
   logic [31:0]         sum_q, sum_d;
   logic [ADDR_W:0]     count_clamped;

   assign count_clamped = (wordCount > DEPTH_C) ? DEPTH_C : wordCount;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         byte_q  <= '0;
         widx_q  <= '0;
         word_q  <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         byte_q  <= byte_d;
         widx_q  <= widx_d;
         word_q  <= word_d;
         sum_q   <= sum_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      byte_d  = byte_q;
      widx_d  = widx_q;
      word_d  = word_q;
      sum_d   = sum_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               count_d = count_clamped;
               sum_d   = '0;
               byte_d  = '0;
               widx_d  = '0;
               state_d = (count_clamped == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            // inReady is high for the whole of LOAD, so inValid alone marks a handshake
            if (inValid) begin
               word_d[{byte_q, 3'b000} +: 8] = inData;
               byte_d = byte_q + 2'd1;
               if (byte_q == 2'd3) state_d = WRITE;
            end
         end
         WRITE: begin
            sum_d  = sum_q + word_q;
            byte_d = '0;
            if ({1'b0, widx_q} == count_q - 1'b1) begin
               state_d = DONE;
            end else begin
               widx_d  = widx_q + 1'b1;
               state_d = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Moore outputs: decoded from state or taken straight from registers
   assign inReady  = (state_q == LOAD);
   assign memWe    = (state_q == WRITE);
   assign memAddr  = widx_q;
   assign memWdata = word_q;
   assign cpuReset = (state_q != DONE);
   assign busy     = (state_q == LOAD) || (state_q == WRITE);
   assign done     = (state_q == DONE);
   assign checksum = sum_q;

endmodule
